// File: rtl/pool_window_feeder.sv
// Streams row-major pixels into 2x2 stride-2 windows for the pooling unit and
// returns pooled pixels on a valid/ready stream. Optional macro: POOL_FEEDER_TIMEOUT_EN.
module pool_window_feeder #(
    parameter int DATA_W  = 16,
    parameter int IMG_W   = 8,
    parameter int IMG_H   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] win_00,
    output logic [DATA_W-1:0] win_01,
    output logic [DATA_W-1:0] win_10,
    output logic [DATA_W-1:0] win_11,
    output logic              start,
    input  logic              finish,
    input  logic [DATA_W-1:0] pool_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              err
);

    localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_ONE = CW'(1'b1);
    localparam logic [RW-1:0] ROW_ONE = RW'(1'b1);
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        ISSUE   = 2'd1,
        OUT     = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [CW-1:0]     col_r;
    logic [RW-1:0]     row_r;
    logic [DATA_W-1:0] line_buf_r [IMG_W];
    logic [DATA_W-1:0] prev_px_r;
    logic [DATA_W-1:0] win_00_r;
    logic [DATA_W-1:0] win_01_r;
    logic [DATA_W-1:0] win_10_r;
    logic [DATA_W-1:0] win_11_r;
    logic [DATA_W-1:0] out_data_r;
    logic              out_last_r;
    logic              last_pend_r;
    logic              in_hs_s;
    logic              out_hs_s;
    logic              form_s;
    logic              capture_s;
    logic              timeout_s;
    logic              col_last_s;
    logic              row_last_s;

    assign in_ready   = (state_r == COLLECT);
    assign start      = (state_r == ISSUE);
    assign out_valid  = (state_r == OUT);
    assign win_00     = win_00_r;
    assign win_01     = win_01_r;
    assign win_10     = win_10_r;
    assign win_11     = win_11_r;
    assign out_data   = out_data_r;
    assign out_last   = out_last_r;

    assign in_hs_s    = in_valid & in_ready;
    assign out_hs_s   = out_valid & out_ready;
    assign col_last_s = (col_r == COL_MAX);
    assign row_last_s = (row_r == ROW_MAX);
    // A window completes on the odd-column pixel of an odd row.
    assign form_s     = in_hs_s & row_r[0] & col_r[0];
    assign capture_s  = (state_r == ISSUE) & (finish | timeout_s);

`ifdef POOL_FEEDER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] WAIT_ONE  = TW'(1'b1);

    logic [TW-1:0] wait_cnt_r;
    logic          err_r;

    assign timeout_s = (state_r == ISSUE) & ~finish & (wait_cnt_r == WAIT_LAST);
    assign err       = err_r;

    // Wait counter restarts on every ISSUE entry; err latches until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_r <= {TW{1'b0}};
            err_r      <= 1'b0;
        end else begin
            if (state_r == ISSUE) begin
                wait_cnt_r <= wait_cnt_r + WAIT_ONE;
            end else begin
                wait_cnt_r <= {TW{1'b0}};
            end
            if (timeout_s) begin
                err_r <= 1'b1;
            end
        end
    end
`else
    assign timeout_s = 1'b0;
    assign err       = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= COLLECT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            COLLECT: begin
                if (form_s) begin
                    state_nxt_s = ISSUE;
                end else begin
                    state_nxt_s = COLLECT;
                end
            end
            ISSUE: begin
                if (finish || timeout_s) begin
                    state_nxt_s = OUT;
                end else begin
                    state_nxt_s = ISSUE;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_nxt_s = COLLECT;
                end else begin
                    state_nxt_s = OUT;
                end
            end
            default: state_nxt_s = COLLECT;
        endcase
    end

    // Pixel counters, line buffer, window registers and pooled-result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_r       <= {CW{1'b0}};
            row_r       <= {RW{1'b0}};
            prev_px_r   <= {DATA_W{1'b0}};
            win_00_r    <= {DATA_W{1'b0}};
            win_01_r    <= {DATA_W{1'b0}};
            win_10_r    <= {DATA_W{1'b0}};
            win_11_r    <= {DATA_W{1'b0}};
            out_data_r  <= {DATA_W{1'b0}};
            out_last_r  <= 1'b0;
            last_pend_r <= 1'b0;
            for (int i = 0; i < IMG_W; i++) begin
                line_buf_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            if (in_hs_s) begin
                if (!row_r[0]) begin
                    line_buf_r[col_r] <= in_data;
                end else if (!col_r[0]) begin
                    prev_px_r <= in_data;
                end else begin
                    win_00_r    <= line_buf_r[col_r - COL_ONE];
                    win_01_r    <= line_buf_r[col_r];
                    win_10_r    <= prev_px_r;
                    win_11_r    <= in_data;
                    last_pend_r <= row_last_s & col_last_s;
                end
                if (col_last_s) begin
                    col_r <= {CW{1'b0}};
                    row_r <= row_last_s ? {RW{1'b0}} : (row_r + ROW_ONE);
                end else begin
                    col_r <= col_r + COL_ONE;
                end
            end
            // On timeout the pooled pixel is replaced by zero but the frame marker survives.
            if (capture_s) begin
                out_data_r <= finish ? pool_result : {DATA_W{1'b0}};
                out_last_r <= last_pend_r;
            end else if (out_hs_s) begin
                out_last_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pool_window_feeder.sv
// Directed bench for pool_window_feeder (IMG_W=4, IMG_H=2) with an averaging pooling model.
module tb_pool_window_feeder;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [DW-1:0] win_00, win_01, win_10, win_11;
    logic          start;
    logic          finish;
    logic [DW-1:0] pool_result;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          err;

    int n_checks = 0;
    int n_fail = 0;

    logic force_finish = 1'b0;
    logic fin_block = 1'b0;
    int   fin_delay = 0;
    int   start_cnt = 0;
    logic [DW+1:0] sum_s;

    pool_window_feeder #(.DATA_W(DW), .IMG_W(4), .IMG_H(2), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .win_00(win_00), .win_01(win_01), .win_10(win_10), .win_11(win_11),
        .start(start), .finish(finish), .pool_result(pool_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .err(err)
    );

    always #5 clk = ~clk;

    // Averaging pooling model with programmable finish delay.
    assign sum_s = {2'b00, win_00} + {2'b00, win_01} + {2'b00, win_10} + {2'b00, win_11};
    assign pool_result = sum_s[DW+1:2];
    assign finish = force_finish | (start & ~fin_block & (start_cnt >= fin_delay));

    always @(posedge clk) begin
        if (!start || finish) start_cnt <= 0;
        else start_cnt <= start_cnt + 1;
    end

    task automatic send_px(input int v);
        in_valid = 1'b1;
        in_data  = DW'(v);
        for (int k = 0; k < 60; k++) begin
            if (in_ready) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n_checks++; n_fail++;
        $display("FAIL send_timeout: pixel %0d never accepted", v);
    endtask

    task automatic send_range(input int lo, input int hi);
        for (int v = lo; v <= hi; v++) send_px(v);
    endtask

    task automatic accept();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_checks++;
        if ({start, out_valid, out_last, err, out_data, win_00, win_01, win_10, win_11} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: start=%b ov=%b last=%b err=%b data=%0d", start, out_valid, out_last, err, out_data);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        send_range(1, 6);
        n_checks++;
        if ({start, in_ready} !== 2'b10) begin n_fail++; $display("FAIL basic_issue: start/in_ready=%b expected 10", {start, in_ready}); end
        n_checks++;
        if ({win_00, win_01, win_10, win_11} !== {16'd1, 16'd2, 16'd5, 16'd6}) begin
            n_fail++; $display("FAIL basic_win0: got %0d %0d %0d %0d expected 1 2 5 6", win_00, win_01, win_10, win_11);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({out_valid, start, out_last} !== 3'b100 || out_data !== 16'd3) begin
            n_fail++; $display("FAIL basic_out0: ov/start/last=%b data=%0d expected 100 data 3", {out_valid, start, out_last}, out_data);
        end
        accept();
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin n_fail++; $display("FAIL basic_after0: ov/in_ready=%b expected 01", {out_valid, in_ready}); end
        send_range(7, 8);
        n_checks++;
        if ({win_00, win_01, win_10, win_11} !== {16'd3, 16'd4, 16'd7, 16'd8}) begin
            n_fail++; $display("FAIL basic_win1: got %0d %0d %0d %0d expected 3 4 7 8", win_00, win_01, win_10, win_11);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({out_valid, out_last} !== 2'b11 || out_data !== 16'd5) begin
            n_fail++; $display("FAIL basic_out1: ov/last=%b data=%0d expected 11 data 5", {out_valid, out_last}, out_data);
        end
        accept();
        n_checks++;
        if ({out_valid, out_last, in_ready} !== 3'b001) begin n_fail++; $display("FAIL basic_end: ov/last/in_ready=%b expected 001", {out_valid, out_last, in_ready}); end
    endtask

    task automatic test_backpressure();
        send_range(1, 6);
        @(posedge clk); #1;
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if ({out_valid, in_ready} !== 2'b10 || out_data !== 16'd3) begin
                n_fail++; $display("FAIL bp_hold%0d: ov/in_ready=%b data=%0d expected 10 data 3", c, {out_valid, in_ready}, out_data);
            end
            @(posedge clk); #1;
        end
        accept();
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin n_fail++; $display("FAIL bp_release: ov/in_ready=%b expected 01", {out_valid, in_ready}); end
        send_range(7, 8);
        @(posedge clk); #1;
        n_checks++;
        if (out_data !== 16'd5 || out_last !== 1'b1) begin n_fail++; $display("FAIL bp_out1: data=%0d last=%b expected 5 1", out_data, out_last); end
        accept();
    endtask

    task automatic test_slow_finish();
        int cnt;
        fin_delay = 3;
        send_range(1, 6);
        cnt = 0;
        while (start && cnt < 20) begin
            cnt++;
            n_checks++;
            if ({win_00, win_01, win_10, win_11} !== {16'd1, 16'd2, 16'd5, 16'd6}) begin
                n_fail++; $display("FAIL slow_win_stable: got %0d %0d %0d %0d expected 1 2 5 6", win_00, win_01, win_10, win_11);
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (cnt !== 4) begin n_fail++; $display("FAIL slow_start_len: got %0d cycles expected 4", cnt); end
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 16'd3) begin n_fail++; $display("FAIL slow_out: ov=%b data=%0d expected 1 3", out_valid, out_data); end
        accept();
        send_range(7, 8);
        for (int k = 0; k < 20 && !out_valid; k++) begin @(posedge clk); #1; end
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 16'd5 || out_last !== 1'b1) begin
            n_fail++; $display("FAIL slow_out1: ov=%b data=%0d last=%b expected 1 5 1", out_valid, out_data, out_last);
        end
        accept();
        fin_delay = 0;
    endtask

    task automatic test_reset_mid();
        send_range(1, 5);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({start, out_valid, out_last, err, out_data, win_00, win_01, win_10, win_11} !== '0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL midreset_outputs: data=%0d win00=%0d win11=%0d in_ready=%b", out_data, win_00, win_11, in_ready);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        send_range(1, 6);
        @(posedge clk); #1;
        n_checks++;
        if (out_data !== 16'd3 || out_last !== 1'b0) begin n_fail++; $display("FAIL midreset_out0: data=%0d last=%b expected 3 0", out_data, out_last); end
        accept();
        send_range(7, 8);
        @(posedge clk); #1;
        n_checks++;
        if (out_data !== 16'd5 || out_last !== 1'b1) begin n_fail++; $display("FAIL midreset_out1: data=%0d last=%b expected 5 1", out_data, out_last); end
        accept();
    endtask

    task automatic test_spurious_finish();
        send_range(1, 2);
        force_finish = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({out_valid, start, in_ready} !== 3'b001) begin
                n_fail++; $display("FAIL spurious_state%0d: ov/start/in_ready=%b expected 001", c, {out_valid, start, in_ready});
            end
        end
        force_finish = 1'b0;
        send_range(3, 6);
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 16'd3) begin n_fail++; $display("FAIL spurious_out0: ov=%b data=%0d expected 1 3", out_valid, out_data); end
        accept();
        send_range(7, 8);
        @(posedge clk); #1;
        n_checks++;
        if (out_data !== 16'd5 || out_last !== 1'b1) begin n_fail++; $display("FAIL spurious_out1: data=%0d last=%b expected 5 1", out_data, out_last); end
        accept();
    endtask

    task automatic test_timeout();
`ifdef POOL_FEEDER_TIMEOUT_EN
        int cnt;
        fin_block = 1'b1;
        send_range(1, 6);
        cnt = 0;
        while (start && cnt < 40) begin
            cnt++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (cnt !== 15) begin n_fail++; $display("FAIL timeout_len: got %0d cycles expected 15", cnt); end
        n_checks++;
        if ({out_valid, err, out_last} !== 3'b110 || out_data !== 16'd0) begin
            n_fail++; $display("FAIL timeout_out: ov/err/last=%b data=%0d expected 110 data 0", {out_valid, err, out_last}, out_data);
        end
        accept();
        fin_block = 1'b0;
        send_range(7, 8);
        @(posedge clk); #1;
        n_checks++;
        if (out_data !== 16'd5 || err !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky: data=%0d err=%b expected 5 1", out_data, err); end
        accept();
`else
        n_checks++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL err_tied: got %b expected 0", err); end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_slow_finish();
        test_reset_mid();
        test_spurious_finish();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pool_window_feeder.md
Name: pool_window_feeder

Overview:
- Initiator-side companion to the 2x2 average-pooling unit.
- Accepts a row-major pixel stream with a valid/ready handshake and buffers one image row.
- Forms non-overlapping 2x2 windows at stride 2 and drives each window to the pooling unit under the start/finish handshake.
- Captures the pooled pixel and emits it on an output valid/ready stream, with a last-of-frame marker.

Parameters:
DATA_W, 16, pixel width (Q-format bits are passed through untouched)
IMG_W, 8, image width in pixels; must be even and >= 2
IMG_H, 8, image height in pixels; must be even and >= 2
TIMEOUT, 15, max cycles to wait for finish (used only with the optional feature)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input pixel valid
in_ready  out  1  feeder can accept an input pixel
in_data  in  DATA_W  input pixel, row-major order
win_00  out  DATA_W  window top-left pixel, to pooling image_in[0][0]
win_01  out  DATA_W  window top-right pixel, to image_in[0][1]
win_10  out  DATA_W  window bottom-left pixel, to image_in[1][0]
win_11  out  DATA_W  window bottom-right pixel, to image_in[1][1]
start  out  1  window valid, request to the pooling unit
finish  in  1  pooling unit done
pool_result  in  DATA_W  pooling unit pixel_out
out_valid  out  1  pooled pixel valid
out_ready  in  1  downstream accepts the pooled pixel
out_data  out  DATA_W  pooled pixel
out_last  out  1  high with out_valid on the final window of the frame
err  out  1  sticky timeout flag (optional feature only; tied 0 otherwise)

Behaviour:
- Interface: one clock domain. rst_n is asynchronous and active-low. All state is reset to 0 when rst_n is low.
- Values after reset:
  - start, out_valid, out_last, err, out_data and win_* are 0.
  - State is COLLECT, so in_ready = 1.
- Counters:
  - col runs 0..IMG_W-1 and row runs 0..IMG_H-1. Both advance on each input handshake (in_valid & in_ready).
  - col wraps to 0 at IMG_W-1 and row increments at that point. row wraps to 0 after the last pixel of the frame.
- Line buffer: IMG_W x DATA_W registers. Every pixel accepted on an even row is written to line_buf[col].
- Odd row, even col: the pixel is held in prev_px.
- Odd row, odd col, on the handshake cycle T:
  - win_00 = line_buf[col-1], win_01 = line_buf[col], win_10 = prev_px, win_11 = in_data.
  - win_* are registered at T. Next state is ISSUE.
- FSM states: COLLECT, ISSUE, OUT.
  - COLLECT: in_ready = 1 and start = 0.
  - ISSUE: start = 1 and in_ready = 0. win_* are held stable while start is high.
    - If finish = 1 in a cycle: capture pool_result into out_data, go to OUT, and start drops the next cycle.
    - If finish = 0: stay in ISSUE.
  - OUT: out_valid = 1 and in_ready = 0. out_data and out_last are held stable until out_ready = 1.
    - On the output handshake, return to COLLECT.
- Latency: against a combinational pooling unit (finish = start), start is high at T+1 and out_valid is high at T+2.
- finish is ignored outside ISSUE. start is never asserted outside ISSUE.
- out_last = 1 when the window was formed at row = IMG_H-1, col = IMG_W-1. The counters have already wrapped to 0 by then, so out_last is a flag registered at window formation.
- Frame output: (IMG_W/2)*(IMG_H/2) pooled pixels in raster order. The next frame may begin immediately after the final output handshake.
- Reset mid-frame: the partial frame is discarded. Counters, line buffer contents and pending output are cleared. The first pixel after reset is treated as row 0, col 0.
- Widths: pool_result passes to out_data unmodified. No arithmetic is done in this block.

Optional Feature:
- Macro: POOL_FEEDER_TIMEOUT_EN.
- Defined:
  - A wait counter runs in ISSUE and is cleared on ISSUE entry.
  - If TIMEOUT cycles elapse without finish: drop start, set err = 1 (sticky until reset), load out_data = 0 and go to OUT. out_last is kept.
- Undefined: no counter exists, ISSUE waits indefinitely and err is tied to 0.

Test Plan:
- IMG_W=4, IMG_H=2, averaging model (sum>>2), stream 1..8 with no stalls -> out_data 3, then 5. out_last = 1 only on 5. win_* = (1,2,5,6), then (3,4,7,8).
- Same stream, out_ready low for 5 cycles after out_valid rises -> in_ready = 0, out_data = 3 stable throughout. Accepted on the cycle out_ready rises; in_ready = 1 the next cycle.
- Pooling model delays finish 3 cycles after start -> start high exactly 4 cycles with win_* stable. out_valid rises the cycle after finish.
- rst_n pulled low asynchronously mid-row 1 -> all outputs 0 immediately. A fresh 8-pixel frame afterwards yields 3, 5.
- Spurious finish = 1 while in COLLECT -> no output, no state change.
- With POOL_FEEDER_TIMEOUT_EN, TIMEOUT=15, finish held 0 -> start drops after 15 cycles, err = 1, out_valid with out_data = 0.
